// File: rtl/mips_defs.sv
// mips_defs: shared constants and next-PC select encodings for the MIPS pipeline
package mips_defs;
  localparam logic [31:0] START_PC = 32'h0000_3000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [1:0] NPC_SEQ = 2'd0;
  localparam logic [1:0] NPC_BR  = 2'd1;
  localparam logic [1:0] NPC_J   = 2'd2;
  localparam logic [1:0] NPC_JR  = 2'd3;
endpackage

// File: rtl/npc.sv
// npc: combinational next-PC calculator (seq, branch, j/jal, jr)
module npc
  import mips_defs::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] d_pc,
  input  logic [1:0]  npc_sel,
  input  logic        branch_taken,
  input  logic [25:0] d_imm26,
  input  logic [31:0] jr_target,
  output logic [31:0] npc
);
  logic [31:0] seq_pc;
  logic [31:0] br_pc;
  assign seq_pc = pc + 32'd4;
  assign br_pc  = d_pc + 32'd4 + {{14{d_imm26[15]}}, d_imm26[15:0], 2'b00};
  // jump region comes from d_pc itself, not d_pc+4
  always_comb
    npc = npc_sel == NPC_BR ? (branch_taken ? br_pc : seq_pc) :
          npc_sel == NPC_J  ? {d_pc[31:28], d_imm26, 2'b00} :
          npc_sel == NPC_JR ? jr_target : seq_pc;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, next-PC selection and IF/ID pipeline register
module fetch_stage
  import mips_defs::*;
#(
  parameter logic [31:0] START_PC  = mips_defs::START_PC,
  parameter logic [31:0] NOP_INSTR = mips_defs::NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        d_clr,
  input  logic [1:0]  npc_sel,
  input  logic        branch_taken,
  input  logic [25:0] d_imm26,
  input  logic [31:0] jr_target,
  input  logic [31:0] im_instr,
  output logic [31:0] pc,
  output logic [31:0] d_instr,
  output logic [31:0] d_pc,
  output logic [31:0] d_pc8
);
  logic [31:0] next_pc;
  npc u_npc (
    .pc(pc),
    .d_pc(d_pc),
    .npc_sel(npc_sel),
    .branch_taken(branch_taken),
    .d_imm26(d_imm26),
    .jr_target(jr_target),
    .npc(next_pc)
  );
  // a clear still records d_pc so a later exception path has an EPC
  always_ff @(posedge clk)
    if (reset) begin
      pc      <= START_PC;
      d_instr <= NOP_INSTR;
      d_pc    <= START_PC;
      d_pc8   <= START_PC + 32'd8;
    end else if (!stall) begin
      pc      <= next_pc;
      d_instr <= d_clr ? NOP_INSTR : im_instr;
      d_pc    <= pc;
      d_pc8   <= pc + 32'd8;
    end
endmodule
